// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
//    Initiator side of the single-port memory req/busy protocol. Accepts one
//    command at a time from a valid/ready host port, issues a one-cycle req to
//    the memory, follows memBusy until the memory finishes and then returns a
//    one-cycle response to the host.
//
//    Optional feature macro: MEM_MASTER_TIMEOUT_EN
//       defined     : a timer aborts an access that stays in WAIT_ACK/BUSY for
//                     TIMEOUT cycles; the response then carries rspErr=1 and
//                     rspData=0.
//       not defined : no timer; the master waits for the memory indefinitely
//                     and rspErr is always 0.
//
// Parameters
//    ADDR_W   address width (matches MEM_ADDR_SIZE of the memory)
//    DATA_W   data word width (matches MEM_WORD_SIZE of the memory)
//    TIMEOUT  cycles allowed in WAIT_ACK+BUSY before an abort
//
// Ports
//    clk, reset            clock (rising edge), asynchronous active-high reset
//    cmdValid/cmdReady     host command handshake
//    cmdWr/cmdAddr/cmdWdata  host command: direction, address, write data
//    rspValid              one-cycle response pulse
//    rspData               read data (0 for writes and aborted accesses)
//    rspErr                abort flag, qualified by rspValid
//    memAddr/memDataIn/wr  address, write data and direction to the memory
//    req                   one-cycle request pulse to the memory
//    memBusy               memory busy/acknowledge
//    memDataOut            read data from memory, valid when memBusy falls
// -----------------------------------------------------------------------------
module mem_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmdValid,
   output logic              cmdReady,
   input  logic              cmdWr,
   input  logic [ADDR_W-1:0] cmdAddr,
   input  logic [DATA_W-1:0] cmdWdata,
   output logic              rspValid,
   output logic [DATA_W-1:0] rspData,
   output logic              rspErr,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memDataIn,
   output logic              wr,
   output logic              req,
   input  logic              memBusy,
   input  logic [DATA_W-1:0] memDataOut
);

   // The abort compares against TIMEOUT-1, so at least one waiting cycle is needed.
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_master: TIMEOUT must be at least 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_BUSY     = 3'd3,
      ST_RESP     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;

   logic                handshake_s;
   logic                waiting_s;
   logic                timeout_s;

   // A new command is only taken once the memory is idle as well, so an
   // aborted access that left memBusy high blocks the host until it drops.
   assign cmdReady    = (state_q == ST_IDLE) & ~memBusy;
   assign handshake_s = cmdValid & cmdReady;
   assign waiting_s   = (state_q == ST_WAIT_ACK) | (state_q == ST_BUSY);

`ifdef MEM_MASTER_TIMEOUT_EN
   localparam int                 TIMER_W    = $clog2(TIMEOUT + 1);
   localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

   logic [TIMER_W-1:0] timer_q, timer_d;

   // Wait-cycle counter: runs only while waiting on the memory, saturating.
   always_comb begin
      timer_d = {TIMER_W{1'b0}};
      if (waiting_s) begin
         if (timer_q == TIMER_MAX) begin
            timer_d = timer_q;
         end else begin
            timer_d = timer_q + TIMER_ONE;
         end
      end else begin
         timer_d = {TIMER_W{1'b0}};
      end
   end

   // Timer register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q <= {TIMER_W{1'b0}};
      end else begin
         timer_q <= timer_d;
      end
   end

   // The edge that would take the timer to TIMEOUT ends the wait, so
   // WAIT_ACK+BUSY together last at most TIMEOUT cycles.
   assign timeout_s = waiting_s & (timer_q == TIMER_LAST);
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state and next-output logic of the access sequencer.
   always_comb begin
      state_d     = state_q;
      req_d       = 1'b0;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = {DATA_W{1'b0}};

      case (state_q)
         ST_IDLE: begin
            if (handshake_s) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               wr_d    = cmdWr;
               addr_d  = cmdAddr;
               wdata_d = cmdWdata;
            end else begin
               state_d = ST_IDLE;
            end
         end

         // req is high during this state only; memBusy is not looked at yet,
         // a memory that answers in the req cycle is picked up in WAIT_ACK.
         ST_REQ: begin
            state_d = ST_WAIT_ACK;
         end

         ST_WAIT_ACK: begin
            if (memBusy) begin
               state_d = ST_BUSY;
            end else if (timeout_s) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               state_d = ST_WAIT_ACK;
            end
         end

         // Completion wins over a simultaneous timeout; read data is taken
         // on the same edge that sees memBusy low.
         ST_BUSY: begin
            if (!memBusy) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               if (wr_q) begin
                  rsp_data_d = {DATA_W{1'b0}};
               end else begin
                  rsp_data_d = memDataOut;
               end
            end else if (timeout_s) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               state_d = ST_BUSY;
            end
         end

         // Response cycle; no accept here, the next command waits for IDLE.
         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered-output flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         req_q       <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         wdata_q     <= {DATA_W{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {DATA_W{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req       = req_q;
   assign wr        = wr_q;
   assign memAddr   = addr_q;
   assign memDataIn = wdata_q;
   assign rspValid  = rsp_valid_q;
   assign rspData   = rsp_data_q;
   assign rspErr    = rsp_err_q;

endmodule

// File: tb/tb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_mem_master
//    Directed bench for mem_master: a table of single accesses with
//    hand-computed results, a randomised write/read-back pass against a
//    scoreboard, and hand-written sequences for the multi-cycle corners
//    (host blocked by a busy memory, reset mid-access, wait/timeout).
//    The bench plays the memory: it stores on req when wr=1 and drives
//    memDataOut from its own array when it drops memBusy.
// -----------------------------------------------------------------------------
module tb_mem_master;

   localparam int TB_TIMEOUT = 16;
`ifdef MEM_MASTER_TIMEOUT_EN
   localparam int MAX_BUSY = TB_TIMEOUT;
`else
   localparam int MAX_BUSY = 20;
`endif

   logic        clk;
   logic        reset;
   logic        cmdValid;
   logic        cmdReady;
   logic        cmdWr;
   logic [7:0]  cmdAddr;
   logic [31:0] cmdWdata;
   logic        rspValid;
   logic [31:0] rspData;
   logic        rspErr;
   logic [7:0]  memAddr;
   logic [31:0] memDataIn;
   logic        wr;
   logic        req;
   logic        memBusy;
   logic [31:0] memDataOut;

   int n_checks = 0;
   int n_fails  = 0;

   logic [31:0] mem_model [0:255];
   logic [31:0] sb        [0:255];

   mem_master #(
      .ADDR_W  (8),
      .DATA_W  (32),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmdValid   (cmdValid),
      .cmdReady   (cmdReady),
      .cmdWr      (cmdWr),
      .cmdAddr    (cmdAddr),
      .cmdWdata   (cmdWdata),
      .rspValid   (rspValid),
      .rspData    (rspData),
      .rspErr     (rspErr),
      .memAddr    (memAddr),
      .memDataIn  (memDataIn),
      .wr         (wr),
      .req        (req),
      .memBusy    (memBusy),
      .memDataOut (memDataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time bound.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Present a command, wait for the handshake, check the req cycle.
   // Returns at the negedge of the cycle after req (WAIT_ACK).
   task automatic start_op(input logic w, input logic [7:0] a, input logic [31:0] d,
                           input logic busy_now);
      int n;
      cmdValid = 1'b1;
      cmdWr    = w;
      cmdAddr  = a;
      cmdWdata = d;
      #1;
      n = 0;
      while (cmdReady !== 1'b1 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) chk("accept_bound", 32'(n), 32'd0);
      @(negedge clk);
      // Scramble the host bus to prove the command was latched.
      cmdValid = 1'b0;
      cmdWr    = ~w;
      cmdAddr  = ~a;
      cmdWdata = ~d;
      chk("req_pulse", req, 1'b1);
      chk("wr_latch", wr, w);
      chk("addr_latch", memAddr, a);
      chk("wdata_latch", memDataIn, d);
      chk("rsp_idle_in_req", rspValid, 1'b0);
      if (wr === 1'b1) mem_model[memAddr] = memDataIn;
      memBusy    = busy_now;
      memDataOut = 32'hBAD0_0BAD;
      @(negedge clk);
      chk("req_single", req, 1'b0);
   endtask

   // Hold memBusy for blen cycles counted from the req cycle, drop it,
   // and check the one-cycle response.
   task automatic finish_op(input logic w, input logic [7:0] a, input logic [31:0] d,
                            input int blen, input logic [31:0] exp_rd);
      for (int i = 2; i <= blen; i++) begin
         @(negedge clk);
         if (wr !== w || memAddr !== a || memDataIn !== d)
            chk("stable_during_busy", {wr, memAddr, memDataIn[22:0]}, {w, a, d[22:0]});
         chk("no_rsp_while_busy", rspValid, 1'b0);
         chk("no_req_while_busy", req, 1'b0);
      end
      memBusy    = 1'b0;
      memDataOut = w ? 32'h0BAD_F00D : mem_model[memAddr];
      @(negedge clk);
      memDataOut = 32'hBAD0_0BAD;
      chk("rsp_valid", rspValid, 1'b1);
      chk("rsp_err", rspErr, 1'b0);
      chk("rsp_data", rspData, exp_rd);
      chk("addr_held_resp", memAddr, a);
      @(negedge clk);
      chk("rsp_one_pulse", rspValid, 1'b0);
      chk("rsp_data_cleared", rspData, 32'h0);
      chk("ready_after", cmdReady, 1'b1);
   endtask

   task automatic run_op(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input int blen, input logic [31:0] exp_rd);
      if (w) sb[a] = d;
      start_op(w, a, d, 1'b1);
      finish_op(w, a, d, blen, exp_rd);
   endtask

   typedef struct {
      logic        w;
      logic [7:0]  addr;
      logic [31:0] data;
      int          blen;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int seen;
      int cnt;
      logic [31:0] rd;

      for (int i = 0; i < 256; i++) begin
         mem_model[i] = 32'h0;
         sb[i]        = 32'h0;
      end

      // Writes return rspData 0; reads return what the table wrote earlier.
      vecs[0] = '{1'b1, 8'h03, 32'hDEAD_BEEF,  5, 32'h0000_0000};
      vecs[1] = '{1'b0, 8'h03, 32'h0000_0000,  3, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 8'h80, 32'h0000_0001,  2, 32'h0000_0000};
      vecs[3] = '{1'b1, 8'hFF, 32'hFFFF_FFFF,  7, 32'h0000_0000};
      vecs[4] = '{1'b0, 8'hFF, 32'h0000_0000,  2, 32'hFFFF_FFFF};
      vecs[5] = '{1'b0, 8'h80, 32'h0000_0000,  9, 32'h0000_0001};
      vecs[6] = '{1'b1, 8'h00, 32'hA5A5_5A5A,  4, 32'h0000_0000};
      vecs[7] = '{1'b0, 8'h00, 32'h0000_0000, 16, 32'hA5A5_5A5A};

      reset      = 1'b1;
      cmdValid   = 1'b0;
      cmdWr      = 1'b0;
      cmdAddr    = 8'h00;
      cmdWdata   = 32'h0;
      memBusy    = 1'b0;
      memDataOut = 32'h0;
      @(negedge clk);
      @(negedge clk);

      // Reset state.
      chk("rst_req", req, 1'b0);
      chk("rst_wr", wr, 1'b0);
      chk("rst_rspValid", rspValid, 1'b0);
      chk("rst_rspErr", rspErr, 1'b0);
      chk("rst_memAddr", memAddr, 8'h00);
      chk("rst_memDataIn", memDataIn, 32'h0);
      chk("rst_rspData", rspData, 32'h0);
      chk("rst_cmdReady", cmdReady, 1'b1);
      reset = 1'b0;
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].blen, vecs[i].exp_rd);
      end

      // Random writes to 0..14, then read-back against the scoreboard.
      for (int i = 0; i < 15; i++) begin
         run_op(1'b1, 8'(i), $urandom, int'($urandom_range(MAX_BUSY, 2)), 32'h0);
      end
      for (int i = 0; i < 15; i++) begin
         rd = sb[i];
         run_op(1'b0, 8'(i), 32'h0, int'($urandom_range(MAX_BUSY, 2)), rd);
      end

      // Host held valid while the memory is still busy: no accept, no req.
      memBusy  = 1'b1;
      cmdValid = 1'b1;
      cmdWr    = 1'b0;
      cmdAddr  = 8'h05;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("blocked_ready", cmdReady, 1'b0);
         chk("blocked_req", req, 1'b0);
      end
      memBusy = 1'b0;
      #1;
      chk("unblocked_ready", cmdReady, 1'b1);
      run_op(1'b0, 8'h05, 32'h0, 3, sb[5]);

      // Reset in the middle of BUSY.
      start_op(1'b0, 8'h06, 32'h0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_req", req, 1'b0);
      chk("midrst_wr", wr, 1'b0);
      chk("midrst_memAddr", memAddr, 8'h00);
      chk("midrst_memDataIn", memDataIn, 32'h0);
      chk("midrst_rspValid", rspValid, 1'b0);
      chk("midrst_rspData", rspData, 32'h0);
      chk("midrst_ready_busy", cmdReady, 1'b0);
      memBusy = 1'b0;
      #1;
      chk("midrst_idle", cmdReady, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_op(1'b0, 8'h03, 32'h0, 4, sb[3]);

      // Memory never answers the req.
      start_op(1'b0, 8'h07, 32'h0, 1'b0);
`ifdef MEM_MASTER_TIMEOUT_EN
      // WAIT_ACK lasts TB_TIMEOUT cycles; counted from its first cycle the
      // response shows up TB_TIMEOUT negedges later.
      cnt = 0;
      while (rspValid !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("timeout_latency", 32'(cnt), 32'(TB_TIMEOUT));
      chk("timeout_err", rspErr, 1'b1);
      chk("timeout_data", rspData, 32'h0);
      @(negedge clk);
      chk("timeout_one_pulse", rspValid, 1'b0);
      chk("timeout_ready", cmdReady, 1'b1);

      // Memory stuck busy: abort, then host stays blocked until it drops.
      start_op(1'b1, 8'h08, 32'h1234_5678, 1'b1);
      cnt = 0;
      while (rspValid !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("stuck_latency", 32'(cnt), 32'(TB_TIMEOUT));
      chk("stuck_err", rspErr, 1'b1);
      @(negedge clk);
      chk("stuck_blocked", cmdReady, 1'b0);
      memBusy = 1'b0;
      #1;
      chk("stuck_released", cmdReady, 1'b1);
      @(negedge clk);
`else
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rspValid === 1'b1) seen++;
      end
      chk("no_rsp_without_timeout", 32'(seen), 32'd0);
      chk("wait_forever_not_ready", cmdReady, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("recover_ready", cmdReady, 1'b1);
`endif

      // One last access after the wait/timeout scenario.
      run_op(1'b0, 8'h03, 32'h0, 2, sb[3]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
